// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and state encoding for the CORDIC issuer.
//   CORDIC_ITERS  iterations performed by the core per operation
//   CORDIC_LAT    cycles from bgn to fin in the nominal core
//   DEF_W/DEF_TMO default data width and watchdog limit
//   state_t       one-hot issuer states
package cordic_pkg;
    localparam int CORDIC_ITERS = 16;
    localparam int CORDIC_LAT   = CORDIC_ITERS + 1;
    localparam int DEF_W        = 16;
    localparam int DEF_TMO      = 24;
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_START = 4'b0010,
        S_WAIT  = 4'b0100,
        S_HOLD  = 4'b1000
    } state_t;
endpackage

// File: rtl/cordic_wdog.sv
// cordic_wdog: saturating watchdog counter for the issuer's WAIT state.
//   clk, rst  clock and asynchronous active-high reset
//   clr       restart the count at zero
//   en        advance the count by one
//   expired   count has reached TMO-1
module cordic_wdog
    import cordic_pkg::*;
#(
    parameter int TMO = DEF_TMO
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TMO);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = cnt_q == CW'(TMO - 1);

    // Holding at the limit keeps the count from wrapping if en lingers.
    always_comb cnt_d = clr ? '0 : (en && !expired) ? cnt_q + CW'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/cordic_issuer.sv
// cordic_issuer: initiator of the CORDIC bgn/fin handshake with watchdog.
//   in_vld/in_rdy/in_ang       angle input stream
//   out_vld/out_rdy            result output stream
//   out_cos/out_sin/out_err    captured result, err marks a timeout
//   cd_bgn/cd_ang              start pulse and held angle to the core
//   cd_fin/cd_cos/cd_sin       completion pulse and result from the core
//   busy                       any state other than IDLE
module cordic_issuer
    import cordic_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int TMO = DEF_TMO
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_ang,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_cos,
    output logic [W-1:0] out_sin,
    output logic         out_err,
    output logic         cd_bgn,
    output logic [W-1:0] cd_ang,
    input  logic         cd_fin,
    input  logic [W-1:0] cd_cos,
    input  logic [W-1:0] cd_sin,
    output logic         busy
);
    state_t       state_q, state_d;
    logic [W-1:0] ang_q, ang_d, cos_q, cos_d, sin_q, sin_d;
    logic         err_q, err_d;
    logic         expired;

    cordic_wdog #(.TMO(TMO)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_q == S_START),
        .en     (state_q == S_WAIT),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        ang_d   = ang_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        err_d   = err_q;
        in_rdy  = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    ang_d   = in_ang;
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                // fin takes priority over a coincident expiry
                if (cd_fin) begin
                    cos_d   = cd_cos;
                    sin_d   = cd_sin;
                    err_d   = 1'b0;
                    state_d = S_HOLD;
                end else if (expired) begin
                    cos_d   = '0;
                    sin_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // A new angle is taken only while the result drains, so
                // back-to-back issue skips IDLE.
                in_rdy = out_rdy;
                if (out_rdy) begin
                    ang_d   = in_vld ? in_ang : ang_q;
                    state_d = in_vld ? S_START : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            ang_q   <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ang_q   <= ang_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
            err_q   <= err_d;
        end

    assign out_vld = state_q == S_HOLD;
    assign cd_bgn  = state_q == S_START;
    assign busy    = state_q != S_IDLE;
    assign cd_ang  = ang_q;
    assign out_cos = cos_q;
    assign out_sin = sin_q;
    assign out_err = err_q;
endmodule
